led_level_driver: RTL and testbench

- Parametrised successor to the single-channel 4-bit LED PWM: drives CHANNELS LED outputs from one shared WIDTH-bit PWM counter, each channel with its own glitch-free duty shadow register.
- Adds audio-reactive modes: a peak-hold envelope tracker on the player's sample stream, with instant attack and timed linear decay, feeding either a bar-graph or a uniform brightness display.
- Sits in the clk_100 domain beside music_player; its sample input connects to the flopped left sample and its new-sample strobe.

---
 rtl/led_level_driver.sv | 128 ++++++++++++
 tb/tb_led_level_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_level_driver.sv
// Multi-channel LED PWM driver with a shared counter, per-channel duty shadows and
// an audio peak-hold envelope that can feed a bar-graph or uniform brightness.

module led_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] target,
    output logic             pwm
);
    logic [WIDTH-1:0] shadow;

    // The compare uses the shadow from before any load on this edge, so the
    // last step of a period still belongs to the old duty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load)
                shadow <= target;
            pwm <= enable && (cnt < shadow);
        end
    end
endmodule

module led_level_driver #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int PRESCALE     = 1,
    parameter int DECAY_DIV    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic [WIDTH-1:0]        duty_in,
    input  logic                    new_sample,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [CHANNELS-1:0]     pwm_out,
    output logic [WIDTH-1:0]        level,
    output logic                    period_start
);
    localparam int CW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW    = $clog2(DECAY_DIV);
    localparam int STEP  = (2 ** WIDTH) / CHANNELS;
    localparam int SHIFT = SAMPLE_WIDTH - 1 - WIDTH;
    localparam logic [WIDTH-1:0]          MAX   = '1;
    localparam logic [SAMPLE_WIDTH-1:0]   MINV  = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic [SAMPLE_WIDTH-2:0]   ONE   = 1;

    logic [CW-1:0]           pre_cnt;
    logic [WIDTH-1:0]        cnt;
    logic [DW-1:0]           dcnt;
    logic                    step, wrap, tick, attack;
    logic [SAMPLE_WIDTH-2:0] mag;
    logic [WIDTH-1:0]        m;

    assign step = (pre_cnt == CW'(PRESCALE - 1));
    assign wrap = step && (cnt == MAX);
    assign tick = (dcnt == DW'(DECAY_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= step ? '0 : pre_cnt + CW'(1);
            if (step)
                cnt <= cnt + WIDTH'(1);
            period_start <= wrap;
        end
    end

    // The most negative sample has no positive twin; clamp it to full scale.
    always_comb begin
        mag = sample[SAMPLE_WIDTH-2:0];
        if (sample[SAMPLE_WIDTH-1])
            mag = (sample == MINV) ? '1 : (~sample[SAMPLE_WIDTH-2:0]) + ONE;
    end

    assign m      = WIDTH'(mag >> SHIFT);
    assign attack = new_sample && (m > level);

    // Attack has priority, so a decay tick landing on an attack is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt  <= '0;
            level <= '0;
        end else begin
            dcnt <= tick ? '0 : dcnt + DW'(1);
            if (attack)
                level <= m;
            else if (tick && level != '0)
                level <= level - WIDTH'(1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [WIDTH-1:0] THRESH = WIDTH'(g * STEP);
        logic [WIDTH-1:0] target;

        always_comb begin
            target = '0;
            case (mode)
                2'b01:   target = duty_in;
                2'b10:   target = (level > THRESH) ? MAX : '0;
                2'b11:   target = level;
                default: target = '0;
            endcase
        end

        led_channel #(.WIDTH(WIDTH)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .load   (wrap),
            .enable (mode != 2'b00),
            .cnt    (cnt),
            .target (target),
            .pwm    (pwm_out[g])
        );
    end
endmodule

// File: tb/tb_led_level_driver.sv
// Scoreboard bench for led_level_driver: WIDTH=4, CHANNELS=4, PRESCALE=1, DECAY_DIV=8.

module tb_led_level_driver;
    logic        clk, reset;
    logic [1:0]  mode;
    logic [3:0]  duty_in;
    logic        new_sample;
    logic [15:0] sample;
    logic [3:0]  pwm_out;
    logic [3:0]  level;
    logic        period_start;

    int total = 0;
    int bad   = 0;
    int cyc;

    typedef struct {
        int         at;
        logic [2:0] m;
        logic [3:0] pwm;
        logic [3:0] lvl;
        logic       ps;
    } exp_t;

    exp_t sb[$];

    led_level_driver #(
        .CHANNELS(4), .WIDTH(4), .SAMPLE_WIDTH(16), .PRESCALE(1), .DECAY_DIV(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .duty_in      (duty_in),
        .new_sample   (new_sample),
        .sample       (sample),
        .pwm_out      (pwm_out),
        .level        (level),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since reset release; edge k is the k-th rising edge.
    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic push(input int at, input logic [2:0] m, input logic [3:0] p,
                        input logic [3:0] l, input logic ps);
        exp_t e;
        e.at = at; e.m = m; e.pwm = p; e.lvl = l; e.ps = ps;
        sb.push_back(e);
    endtask

    // Level after edge k once the 7FFF sample lands on edge 65.
    function automatic logic [3:0] decay_lvl(input int k);
        int v;
        v = 23 - k / 8;
        return (v < 0) ? 4'd0 : 4'(v);
    endfunction

    // Bar-graph output after edge k: shadows are 0 or 15, latched at the boundary.
    function automatic logic [3:0] bar_pwm(input int k);
        int b, c;
        logic [3:0] l, msk;
        b = ((k - 1) / 16) * 16;
        c = (k - 1) % 16;
        if (b == 64) return (c < 12) ? 4'hF : 4'h0;
        l = decay_lvl(b - 1);
        for (int i = 0; i < 4; i++) msk[i] = (l > 4 * i);
        return (c < 15) ? msk : 4'h0;
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (pwm_out !== 4'h0) begin bad++; $display("FAIL reset_pwm got=%h want=0", pwm_out); end
        total++; if (level !== 4'h0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_ps got=%b want=0", period_start); end
        reset = 1'b0;
    endtask

    task automatic test_static;
        exp_t e;
        mode = 2'b01; duty_in = 4'd4;
        for (int k = 1; k <= 64; k++)
            push(k, 3'b111,
                 ((k >= 17 && k <= 20) || (k >= 33 && k <= 36) || (k >= 49 && k <= 60)) ? 4'hF : 4'h0,
                 4'h0, (k % 16 == 0));
        while (cyc < 64) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.m[0]) begin total++; if (pwm_out !== e.pwm) begin bad++; $display("FAIL static_pwm cyc=%0d got=%h want=%h", cyc, pwm_out, e.pwm); end end
                if (e.m[1]) begin total++; if (level !== e.lvl) begin bad++; $display("FAIL static_level cyc=%0d got=%0d want=%0d", cyc, level, e.lvl); end end
                if (e.m[2]) begin total++; if (period_start !== e.ps) begin bad++; $display("FAIL static_ps cyc=%0d got=%b want=%b", cyc, period_start, e.ps); end end
            end
            if (cyc == 34) duty_in = 4'd12;
        end
    endtask

    task automatic test_attack;
        exp_t e;
        mode = 2'b10; new_sample = 1'b1; sample = 16'h7FFF;
        for (int k = 65; k <= 96; k++) push(k, 3'b111, bar_pwm(k), decay_lvl(k), (k % 16 == 0));
        while (cyc < 96) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.m[0]) begin total++; if (pwm_out !== e.pwm) begin bad++; $display("FAIL attack_pwm cyc=%0d got=%h want=%h", cyc, pwm_out, e.pwm); end end
                if (e.m[1]) begin total++; if (level !== e.lvl) begin bad++; $display("FAIL attack_level cyc=%0d got=%0d want=%0d", cyc, level, e.lvl); end end
                if (e.m[2]) begin total++; if (period_start !== e.ps) begin bad++; $display("FAIL attack_ps cyc=%0d got=%b want=%b", cyc, period_start, e.ps); end end
            end
            if (cyc == 65) new_sample = 1'b0;
        end
    endtask

    task automatic test_decay;
        exp_t e;
        for (int k = 97; k <= 208; k++) push(k, 3'b111, bar_pwm(k), decay_lvl(k), (k % 16 == 0));
        while (cyc < 208) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.m[0]) begin total++; if (pwm_out !== e.pwm) begin bad++; $display("FAIL decay_pwm cyc=%0d got=%h want=%h", cyc, pwm_out, e.pwm); end end
                if (e.m[1]) begin total++; if (level !== e.lvl) begin bad++; $display("FAIL decay_level cyc=%0d got=%0d want=%0d", cyc, level, e.lvl); end end
                if (e.m[2]) begin total++; if (period_start !== e.ps) begin bad++; $display("FAIL decay_ps cyc=%0d got=%b want=%b", cyc, period_start, e.ps); end end
            end
        end
    endtask

    task automatic test_saturation;
        exp_t e;
        new_sample = 1'b1; sample = 16'h8000;
        push(209, 3'b010, 4'h0, 4'd15, 1'b0);
        push(327, 3'b010, 4'h0, 4'd1, 1'b0);
        push(328, 3'b010, 4'h0, 4'd0, 1'b0);
        push(331, 3'b010, 4'h0, 4'd2, 1'b0);
        push(333, 3'b010, 4'h0, 4'd5, 1'b0);
        push(335, 3'b010, 4'h0, 4'd5, 1'b0);
        push(336, 3'b010, 4'h0, 4'd4, 1'b0);
        while (cyc < 336) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.m[1]) begin total++; if (level !== e.lvl) begin bad++; $display("FAIL sat_level cyc=%0d got=%0d want=%0d", cyc, level, e.lvl); end end
            end
            new_sample = 1'b0;
            case (cyc)
                330: begin new_sample = 1'b1; sample = 16'h1000; end
                332: begin new_sample = 1'b1; sample = 16'h2800; end
                334: begin new_sample = 1'b1; sample = 16'hF000; end
                default: ;
            endcase
        end
    endtask

    task automatic test_collision;
        exp_t e;
        push(338, 3'b010, 4'h0, 4'd6, 1'b0);
        push(343, 3'b010, 4'h0, 4'd6, 1'b0);
        push(344, 3'b010, 4'h0, 4'd9, 1'b0);
        push(351, 3'b010, 4'h0, 4'd9, 1'b0);
        push(352, 3'b010, 4'h0, 4'd8, 1'b0);
        while (cyc < 352) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.m[1]) begin total++; if (level !== e.lvl) begin bad++; $display("FAIL collide_level cyc=%0d got=%0d want=%0d", cyc, level, e.lvl); end end
            end
            new_sample = 1'b0;
            if (cyc == 337) begin new_sample = 1'b1; sample = 16'h3000; end
            if (cyc == 343) begin new_sample = 1'b1; sample = 16'h4800; end
        end
    endtask

    task automatic test_off_reset;
        exp_t e;
        mode = 2'b11; new_sample = 1'b1; sample = 16'h5000;
        push(353, 3'b010, 4'h0, 4'd10, 1'b0);
        push(367, 3'b010, 4'h0, 4'd9, 1'b0);
        push(368, 3'b110, 4'h0, 4'd8, 1'b1);
        push(370, 3'b001, 4'hF, 4'h0, 1'b0);
        push(371, 3'b001, 4'h0, 4'h0, 1'b0);
        push(372, 3'b011, 4'hF, 4'd8, 1'b0);
        while (cyc < 372) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.m[0]) begin total++; if (pwm_out !== e.pwm) begin bad++; $display("FAIL off_pwm cyc=%0d got=%h want=%h", cyc, pwm_out, e.pwm); end end
                if (e.m[1]) begin total++; if (level !== e.lvl) begin bad++; $display("FAIL off_level cyc=%0d got=%0d want=%0d", cyc, level, e.lvl); end end
                if (e.m[2]) begin total++; if (period_start !== e.ps) begin bad++; $display("FAIL off_ps cyc=%0d got=%b want=%b", cyc, period_start, e.ps); end end
            end
            if (cyc == 353) new_sample = 1'b0;
            if (cyc == 370) mode = 2'b00;
            if (cyc == 371) mode = 2'b11;
        end
        #2 reset = 1'b1;
        #1;
        total++; if (pwm_out !== 4'h0) begin bad++; $display("FAIL async_pwm got=%h want=0", pwm_out); end
        total++; if (level !== 4'h0) begin bad++; $display("FAIL async_level got=%0d want=0", level); end
        total++; if (period_start !== 1'b0) begin bad++; $display("FAIL async_ps got=%b want=0", period_start); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) push(k, 3'b111, 4'h0, 4'h0, (k == 16));
        while (cyc < 17) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.m[0]) begin total++; if (pwm_out !== e.pwm) begin bad++; $display("FAIL rel_pwm cyc=%0d got=%h want=%h", cyc, pwm_out, e.pwm); end end
                if (e.m[1]) begin total++; if (level !== e.lvl) begin bad++; $display("FAIL rel_level cyc=%0d got=%0d want=%0d", cyc, level, e.lvl); end end
                if (e.m[2]) begin total++; if (period_start !== e.ps) begin bad++; $display("FAIL rel_ps cyc=%0d got=%b want=%b", cyc, period_start, e.ps); end end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mode = 2'b00; duty_in = 4'd0; new_sample = 1'b0; sample = 16'h0;
        test_reset;
        test_static;
        test_attack;
        test_decay;
        test_saturation;
        test_collision;
        test_off_reset;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
